sar_search: RTL and testbench
=============================

Name: sar_search

Overview:
- Successive-approximation search engine: the initiator side of the magnitude-comparator interface.
- Drives a trial operand into an external combinational comparator, reads back its greater / less / equal flags, and resolves one bit per cycle, MSB first.
- Result is the largest value not exceeding the comparator's other operand (the target).
- Sits beside the 4-bit comparator in the datapath as its controller.

Parameters:
- WIDTH, 4, operand width in bits; the search takes WIDTH trial cycles.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a new search; accepted only when busy=0.
- cmp_gt  in  1  comparator flag: target > trial.
- cmp_lt  in  1  comparator flag: target < trial.
- cmp_eq  in  1  comparator flag: target == trial.
- trial  out  WIDTH  registered operand driven to the comparator.
- busy  out  1  high in TRIAL and VERIFY.
- done  out  1  one-cycle pulse when the result is valid.
- result  out  WIDTH  final search value; holds until the next accepted start.
- found  out  1  target equals result; holds with result.
- err  out  1  sticky per search; set on an invalid comparator code.

Behaviour:
- Interface: clk and rst as above; reset is synchronous, active-high.
- Reset values: state=IDLE; trial, result, found, err, busy and done all 0. Reset mid-search aborts immediately with no done pulse.
- States are IDLE, TRIAL, VERIFY and DONE.
- IDLE/DONE + start:
  - trial <= 1<<(WIDTH-1); idx <= WIDTH-1; eq_seen, err, found <= 0.
  - Go to TRIAL.
  - A start in DONE is accepted the same as in IDLE.
- Comparator flags are sampled in the same cycle trial is presented, because the comparator is combinational.
- Valid code: exactly one of gt/lt/eq is set. Any other code sets err and is treated as gt (keep bit).
- TRIAL, per cycle:
  - If cmp_lt, clear trial[idx]. If cmp_eq, set eq_seen.
  - If idx>0: set trial[idx-1], decrement idx, stay in TRIAL.
  - If idx==0 and eq_seen or eq on this cycle: result <= updated trial; found <= 1; go to DONE.
  - If idx==0 otherwise: go to VERIFY with trial = updated value.
- VERIFY (one cycle): result <= trial; found <= cmp_eq; err updated by code check; go to DONE.
- DONE: done=1 for one cycle. Go to IDLE unless start is high.
- Latency from the start-accept edge to done: WIDTH+1 cycles with an eq hit, WIDTH+2 with VERIFY.
- Width and overflow:
  - Trial bits are only ever set at idx, so there is no overflow.
  - A target above 2^WIDTH-1 is outside the comparator interface; such a target yields all-ones with found=0.
- start while busy is ignored. cmp_* are ignored outside TRIAL and VERIFY.

Optional Feature:
- Macro: SAR_EARLY_EXIT_EN.
- Defined: cmp_eq in any TRIAL cycle finishes immediately. result <= current trial, found <= 1, go to DONE; remaining bits are skipped.
- Undefined: always the full WIDTH trials, giving fixed latency except for VERIFY.

Decomposition:
- Package sar_pkg holds:
  - the state enum (IDLE, TRIAL, VERIFY, DONE);
  - the comparator code constants (CMP_GT, CMP_LT, CMP_EQ as a 3-bit {gt,lt,eq} one-hot);
  - a function that checks the code is one-hot.
- No sub-module is needed; the comparator stays external and is instantiated only in the bench.
- The bench drives the comparator with (a=target, b=trial) and maps A→cmp_gt, B→cmp_lt, S→cmp_eq.

Test Plan (WIDTH=4, comparator in bench):
- target=11, start pulse:
  - trials are 8, 12, 10, 11;
  - done pulses 5 cycles after the accept edge;
  - result=11, found=1, err=0.
- target=0:
  - trials are 8, 4, 2, 1, then VERIFY with 0;
  - result=0, found=1, done after 6 cycles.
- target=8 with SAR_EARLY_EXIT_EN:
  - eq on the first trial, done the next cycle, result=8, found=1;
  - without the macro, trials are 8, 12, 10, 9, result=8, found=1.
- Bench forces cmp_gt=cmp_lt=1 on cycle 2 with target=5:
  - err=1 and the bit is kept;
  - err stays set until the next start.
- Asserting rst during the third trial: next cycle is IDLE with all outputs 0, and no done pulse appears.
- start held high continuously:
  - back-to-back searches run;
  - a start in DONE restarts with trial=8 on the following cycle;
  - start pulses while busy have no effect.

Source files
------------

// File: rtl/sar_pkg.sv
// Shared definitions for the successive-approximation search controller:
// state encoding and the {gt,lt,eq} comparator code.
package sar_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_TRIAL  = 2'd1;
    localparam state_t ST_VERIFY = 2'd2;
    localparam state_t ST_DONE   = 2'd3;

    localparam logic [2:0] CMP_GT = 3'b100;
    localparam logic [2:0] CMP_LT = 3'b010;
    localparam logic [2:0] CMP_EQ = 3'b001;

    function automatic logic cmp_code_valid(input logic [2:0] code);
        return (code == CMP_GT) || (code == CMP_LT) || (code == CMP_EQ);
    endfunction

endpackage

// File: rtl/sar_search.sv
// Successive-approximation search driving an external combinational comparator.
// Optional SAR_EARLY_EXIT_EN: finish as soon as any trial compares equal.
//
// state  | meaning
// IDLE   | waiting for start
// TRIAL  | trial presented, resolving bit idx this cycle
// VERIFY | one extra compare of the fully resolved value
// DONE   | done pulse; start here restarts immediately
module sar_search
    import sar_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cmp_gt,
    input  logic             cmp_lt,
    input  logic             cmp_eq,
    output logic [WIDTH-1:0] trial,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             found,
    output logic             err
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] TRIAL_MSB = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             eq_seen;
    logic [2:0]       code;
    logic             code_ok;
    logic             hit_lt;
    logic             hit_eq;
    logic             last;
    logic [WIDTH-1:0] trial_upd;
    logic [WIDTH-1:0] next_bit;

    assign code    = {cmp_gt, cmp_lt, cmp_eq};
    assign code_ok = cmp_code_valid(code);
    // an invalid code behaves like gt: the bit under test is kept
    assign hit_lt  = code_ok & cmp_lt;
    assign hit_eq  = code_ok & cmp_eq;
    assign last    = (idx == '0);
    assign next_bit = WIDTH'(1) << (idx - 1'b1);

    always_comb begin
        trial_upd = trial;
        if (hit_lt)
            trial_upd[idx] = 1'b0;
    end

    assign busy = (state == ST_TRIAL) || (state == ST_VERIFY);
    assign done = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            trial   <= '0;
            idx     <= '0;
            eq_seen <= 1'b0;
            result  <= '0;
            found   <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        trial   <= TRIAL_MSB;
                        idx     <= IDX_W'(WIDTH - 1);
                        eq_seen <= 1'b0;
                        err     <= 1'b0;
                        found   <= 1'b0;
                        state   <= ST_TRIAL;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_TRIAL: begin
                    if (!code_ok)
                        err <= 1'b1;
                    if (hit_eq)
                        eq_seen <= 1'b1;
`ifdef SAR_EARLY_EXIT_EN
                    if (hit_eq) begin
                        result <= trial;
                        found  <= 1'b1;
                        state  <= ST_DONE;
                    end else
`endif
                    if (!last) begin
                        trial <= trial_upd | next_bit;
                        idx   <= idx - 1'b1;
                    end else if (eq_seen || hit_eq) begin
                        trial  <= trial_upd;
                        result <= trial_upd;
                        found  <= 1'b1;
                        state  <= ST_DONE;
                    end else begin
                        trial <= trial_upd;
                        state <= ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    result <= trial;
                    found  <= hit_eq;
                    if (!code_ok)
                        err <= 1'b1;
                    state <= ST_DONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sar_search.sv
// Bench for sar_search with a behavioural 4-bit magnitude comparator and a
// done-time scoreboard; build with or without SAR_EARLY_EXIT_EN.
module tb_sar_search;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             cmp_gt;
    logic             cmp_lt;
    logic             cmp_eq;
    logic [WIDTH-1:0] trial;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             found;
    logic             err;

    logic [WIDTH-1:0] target;
    logic             bad_code;
    logic             exp_bad;

    always #5 clk = ~clk;

    // comparator with a = target, b = trial; bad_code forces gt and lt together
    assign cmp_gt = bad_code | (target > trial);
    assign cmp_lt = bad_code | (target < trial);
    assign cmp_eq = !bad_code && (target == trial);

    sar_search #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .cmp_gt (cmp_gt),
        .cmp_lt (cmp_lt),
        .cmp_eq (cmp_eq),
        .trial  (trial),
        .busy   (busy),
        .done   (done),
        .result (result),
        .found  (found),
        .err    (err)
    );

    typedef struct {
        logic [3:0] result;
        logic       found;
        logic       err;
        int         lat;
        int         acc_cyc;
    } exp_t;

    typedef struct {
        logic [3:0] target;
        logic [3:0] result;
        logic       found;
    } vec_t;

    exp_t       exp_q[$];
    logic [3:0] seen[$];
    logic [3:0] exp_tr[$];
    vec_t       vecs[8];
    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    // cycle (1 = first trial cycle) in which done is high
    function automatic int exp_lat(input logic [3:0] t);
        if (t == 4'd0)
            return WIDTH + 2;
`ifdef SAR_EARLY_EXIT_EN
        for (int b = 0; b < WIDTH; b++)
            if (t[b])
                return WIDTH - b + 1;
`endif
        return WIDTH + 1;
    endfunction

    // scoreboard: pop at done, push when a start will be accepted at the next edge
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (done) begin
            if (exp_q.size() == 0) begin
                check("done_unexpected", done, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("sb_result", result, e.result);
                check("sb_found", found, e.found);
                check("sb_err", err, e.err);
                check("sb_latency", cyc - e.acc_cyc, e.lat);
            end
        end
        if (!rst && start && !busy) begin
            e.result  = target;
            e.found   = 1'b1;
            e.err     = exp_bad;
            e.lat     = exp_lat(target);
            e.acc_cyc = cyc;
            exp_q.push_back(e);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_search(input logic [3:0] t, input int bad_at);
        logic got;
        got      = 1'b0;
        target   = t;
        exp_bad  = (bad_at != 0);
        seen.delete();
        start    = 1'b1;
        tick();
        start    = 1'b0;
        check("start_clears_err", err, 1'b0);
        check("start_clears_found", found, 1'b0);
        for (int k = 1; k <= 20 && !got; k++) begin
            bad_code = (k == bad_at);
            if (busy)
                seen.push_back(trial);
            if (done)
                got = 1'b1;
            else
                tick();
        end
        bad_code = 1'b0;
        exp_bad  = 1'b0;
        check("done_seen", got, 1'b1);
    endtask

    task automatic check_seq(input string name);
        check({name, "_len"}, seen.size(), exp_tr.size());
        for (int i = 0; i < exp_tr.size() && i < seen.size(); i++)
            check({name, "_trial"}, seen[i], exp_tr[i]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish, got running, expected finished");
        $fatal(1);
    end

    initial begin
        int ndone;
        logic got;

        vecs[0] = '{target: 4'd15, result: 4'd15, found: 1'b1};
        vecs[1] = '{target: 4'd1,  result: 4'd1,  found: 1'b1};
        vecs[2] = '{target: 4'd6,  result: 4'd6,  found: 1'b1};
        vecs[3] = '{target: 4'd12, result: 4'd12, found: 1'b1};
        vecs[4] = '{target: 4'd7,  result: 4'd7,  found: 1'b1};
        vecs[5] = '{target: 4'd3,  result: 4'd3,  found: 1'b1};
        vecs[6] = '{target: 4'd10, result: 4'd10, found: 1'b1};
        vecs[7] = '{target: 4'd14, result: 4'd14, found: 1'b1};

        rst      = 1'b1;
        start    = 1'b0;
        target   = 4'd0;
        bad_code = 1'b0;
        exp_bad  = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_trial", trial, 4'd0);
        check("rst_result", result, 4'd0);
        check("rst_found", found, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);

        run_search(4'd11, 0);
        exp_tr = '{4'd8, 4'd12, 4'd10, 4'd11};
        check_seq("t11");
        tick();
        check("done_one_cycle", done, 1'b0);

        run_search(4'd0, 0);
        exp_tr = '{4'd8, 4'd4, 4'd2, 4'd1, 4'd0};
        check_seq("t0");
        tick();

        run_search(4'd8, 0);
`ifdef SAR_EARLY_EXIT_EN
        exp_tr = '{4'd8};
`else
        exp_tr = '{4'd8, 4'd12, 4'd10, 4'd9};
`endif
        check_seq("t8");
        check("t8_result", result, 4'd8);
        tick();

        // invalid code on the second trial (trial=4, true answer gt)
        run_search(4'd5, 2);
        exp_tr = '{4'd8, 4'd4, 4'd6, 4'd5};
        check_seq("t5_bad");
        repeat (3) tick();
        check("err_sticky_idle", err, 1'b1);
        run_search(4'd9, 0);
        check("err_after_restart", err, 1'b0);
        tick();

        for (int i = 0; i < 8; i++) begin
            run_search(vecs[i].target, 0);
            check("vec_result", result, vecs[i].result);
            check("vec_found", found, vecs[i].found);
            tick();
        end

        // reset during the third trial: no done may follow
        target = 4'd11;
        start  = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        exp_q.delete();
        tick();
        rst = 1'b0;
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_trial", trial, 4'd0);
        check("midrst_result", result, 4'd0);
        check("midrst_found", found, 1'b0);
        check("midrst_err", err, 1'b0);
        repeat (8) tick();

        // start held: back-to-back searches, restart straight out of DONE
        target = 4'd11;
        start  = 1'b1;
        ndone  = 0;
        for (int k = 0; k < 60 && ndone < 3; k++) begin
            tick();
            if (done) begin
                ndone++;
                tick();
                check("restart_trial", trial, 4'd8);
                check("restart_busy", busy, 1'b1);
            end
        end
        start = 1'b0;
        check("held_done_count", ndone, 3);
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            tick();
            if (done)
                got = 1'b1;
        end
        check("held_drain_done", got, 1'b1);
        repeat (3) tick();
        check("queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
